// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel pipeline.
package vga_pkg;

    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned TILE_PX      = 40;
    localparam int unsigned BORDER_PX    = 2;
    localparam int unsigned BLINK_FRAMES = 16;
    localparam int unsigned TILES_X      = 16;
    localparam int unsigned TILES_Y      = 12;

    typedef logic [23:0] rgb24_t;

    localparam rgb24_t KEY_COLOR    = 24'hFF00FF;
    localparam rgb24_t CURSOR_COLOR = 24'hFFFF00;

    // Tile index of a 10-bit coordinate; compare chain instead of a divider.
    function automatic logic [4:0] tile_of(input logic [9:0] v);
        logic [4:0] t;
        t = '0;
        for (int unsigned i = 1; i < 26; i++) begin
            if (32'(v) >= i * TILE_PX) t = 5'(i);
        end
        return t;
    endfunction

endpackage

// File: rtl/cursor_blink.sv
// Frame-start detection, blink timer and per-frame cursor tile latch.
module cursor_blink
    import vga_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vs_in,
    input  logic [3:0] cursor_col,
    input  logic [3:0] cursor_row,
    output logic       blink_on,
    output logic [3:0] cur_col_l,
    output logic [3:0] cur_row_l
);

    logic       r_vs_d1;
    logic [3:0] r_frame_cnt;
    logic       r_blink_on;
    logic [3:0] r_col_l;
    logic [3:0] r_row_l;
    logic       w_frame_start;

    assign w_frame_start = r_vs_d1 & ~vs_in;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vs_d1     <= 1'b1;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_col_l     <= '0;
            r_row_l     <= '0;
        end else begin
            r_vs_d1 <= vs_in;
            if (w_frame_start) begin
                // Latch only at frame start so the cursor never tears mid-frame.
                r_col_l <= cursor_col;
                r_row_l <= cursor_row;
                if (r_frame_cnt == 4'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 4'd1;
                end
            end
        end
    end

    assign blink_on  = r_blink_on;
    assign cur_col_l = r_col_l;
    assign cur_row_l = r_row_l;

endmodule

// File: rtl/vga_pixel_pipe.sv
// Map-RAM address generation, sprite/cursor overlay and 2-clock aligned VGA output stage.
module vga_pixel_pipe
    import vga_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_n_in,
    input  logic        sprite_hit,
    input  logic [23:0] sprite_color,
    input  logic        cursor_en,
    input  logic [3:0]  cursor_col,
    input  logic [3:0]  cursor_row,
    output logic [18:0] map_read_address,
    input  logic [23:0] map_data_in,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N
);

    logic       w_active;
    logic [18:0] w_addr;

    assign w_active = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    assign w_addr   = ({9'b0, DrawY} << 9) + ({9'b0, DrawY} << 7) + {9'b0, DrawX};
    assign map_read_address = w_active ? w_addr : '0;

    logic [9:0] r_x_d1, r_y_d1;
    logic       r_hit_d1, r_blank_d1, r_hs_d1, r_vs_d1;
    rgb24_t     r_scol_d1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x_d1     <= '0;
            r_y_d1     <= '0;
            r_hit_d1   <= 1'b0;
            r_scol_d1  <= '0;
            r_blank_d1 <= 1'b0;
            r_hs_d1    <= 1'b1;
            r_vs_d1    <= 1'b1;
        end else begin
            r_x_d1     <= DrawX;
            r_y_d1     <= DrawY;
            r_hit_d1   <= sprite_hit;
            r_scol_d1  <= sprite_color;
            r_blank_d1 <= blank_n_in;
            r_hs_d1    <= hs_in;
            r_vs_d1    <= vs_in;
        end
    end

    logic       w_blink_on;
    logic [3:0] w_cur_col_l, w_cur_row_l;

    cursor_blink u_cursor_blink (
        .Clk        (Clk),
        .Reset      (Reset),
        .vs_in      (vs_in),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .blink_on   (w_blink_on),
        .cur_col_l  (w_cur_col_l),
        .cur_row_l  (w_cur_row_l)
    );

    logic [4:0] w_tile_x, w_tile_y;
    logic [9:0] w_off_x, w_off_y;
    logic       w_border, w_in_tile, w_cursor_vis;

    assign w_tile_x = tile_of(r_x_d1);
    assign w_tile_y = tile_of(r_y_d1);
    assign w_off_x  = 10'(32'(r_x_d1) - 32'(w_tile_x) * TILE_PX);
    assign w_off_y  = 10'(32'(r_y_d1) - 32'(w_tile_y) * TILE_PX);

    assign w_border = (w_off_x < 10'(BORDER_PX)) || (w_off_x >= 10'(TILE_PX - BORDER_PX)) ||
                      (w_off_y < 10'(BORDER_PX)) || (w_off_y >= 10'(TILE_PX - BORDER_PX));
    assign w_in_tile = (w_tile_x == {1'b0, w_cur_col_l}) && (w_tile_y == {1'b0, w_cur_row_l});
    assign w_cursor_vis = cursor_en & w_blink_on &
                          ({1'b0, w_cur_col_l} < 5'(TILES_X)) &
                          ({1'b0, w_cur_row_l} < 5'(TILES_Y));

    rgb24_t w_pix;

    always_comb begin
        w_pix = map_data_in;
        if (!r_blank_d1) begin
            w_pix = '0;
        end else if (w_cursor_vis && w_in_tile && w_border) begin
            w_pix = CURSOR_COLOR;
        end else if (r_hit_d1 && (r_scol_d1 != KEY_COLOR)) begin
            w_pix = r_scol_d1;
        end
    end

    rgb24_t r_rgb_q;
    logic   r_hs_d2, r_vs_d2, r_blank_d2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rgb_q    <= '0;
            r_hs_d2    <= 1'b1;
            r_vs_d2    <= 1'b1;
            r_blank_d2 <= 1'b0;
        end else begin
            r_rgb_q    <= w_pix;
            r_hs_d2    <= r_hs_d1;
            r_vs_d2    <= r_vs_d1;
            r_blank_d2 <= r_blank_d1;
        end
    end

    assign VGA_R       = r_rgb_q[23:16];
    assign VGA_G       = r_rgb_q[15:8];
    assign VGA_B       = r_rgb_q[7:0];
    assign VGA_HS      = r_hs_d2;
    assign VGA_VS      = r_vs_d2;
    assign VGA_BLANK_N = r_blank_d2;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench: directed test-plan cases plus random pixels against a frame-level model.
module tb_vga_pixel_pipe;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        hs_in = 1'b1, vs_in = 1'b1, blank_n_in = 1'b1;
    logic        sprite_hit = 1'b0;
    logic [23:0] sprite_color = '0;
    logic        cursor_en = 1'b0;
    logic [3:0]  cursor_col = '0, cursor_row = '0;
    logic [18:0] map_read_address;
    logic [23:0] map_data_in = '0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;

    always #5 Clk = ~Clk;

    vga_pixel_pipe dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .hs_in            (hs_in),
        .vs_in            (vs_in),
        .blank_n_in       (blank_n_in),
        .sprite_hit       (sprite_hit),
        .sprite_color     (sprite_color),
        .cursor_en        (cursor_en),
        .cursor_col       (cursor_col),
        .cursor_row       (cursor_row),
        .map_read_address (map_read_address),
        .map_data_in      (map_data_in),
        .VGA_R            (VGA_R),
        .VGA_G            (VGA_G),
        .VGA_B            (VGA_B),
        .VGA_HS           (VGA_HS),
        .VGA_VS           (VGA_VS),
        .VGA_BLANK_N      (VGA_BLANK_N)
    );

    function automatic logic [23:0] ram_word(input logic [18:0] a);
        if (a == 19'd1925) return 24'h123456;
        return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C, {a[18:16], a[4:0]}};
    endfunction

    always @(posedge Clk) map_data_in <= ram_word(map_read_address);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_addr(input int x, input int y);
        return (x < 640 && y < 480) ? y * 640 + x : 0;
    endfunction

    // Current stimulus
    int          s_x = 0, s_y = 0, s_col = 0, s_row = 0;
    bit          s_hs = 1, s_vs = 1, s_bn = 1, s_hit = 0, s_cen = 0, s_rst = 1;
    logic [23:0] s_sc = '0;

    // Frame-level model state
    int falls = 0, lcol = 0, lrow = 0;
    bit prev_vs = 1;

    // Previous pixel and what its overlay state was
    int          p_x = 0, p_y = 0, p_lcol = 0, p_lrow = 0;
    bit          p_hit = 0, p_bn = 0, p_hs = 1, p_vs = 1, p_rst = 1, p_blink = 1;
    logic [23:0] p_sc = '0;

    logic [23:0] e_rgb = '0;
    bit          e_hs = 1, e_vs = 1, e_bn = 0;
    bit          started = 0;

    task automatic tick();
        int ox, oy;
        bool_border: begin end
        @(negedge Clk);
        if (started) begin
            check_eq("rgb", {8'b0, VGA_R, VGA_G, VGA_B}, {8'b0, e_rgb});
            check_eq("hs", 32'(VGA_HS), 32'(e_hs));
            check_eq("vs", 32'(VGA_VS), 32'(e_vs));
            check_eq("blank_n", 32'(VGA_BLANK_N), 32'(e_bn));
        end
        DrawX = 10'(s_x);
        DrawY = 10'(s_y);
        hs_in = s_hs;
        vs_in = s_vs;
        blank_n_in = s_bn;
        sprite_hit = s_hit;
        sprite_color = s_sc;
        cursor_en = s_cen;
        cursor_col = 4'(s_col);
        cursor_row = 4'(s_row);
        Reset = s_rst;
        #1;
        check_eq("addr", 32'(map_read_address), 32'(model_addr(s_x, s_y)));

        if (s_rst) begin
            falls = 0; lcol = 0; lrow = 0; prev_vs = 1;
        end else begin
            if (prev_vs && !s_vs) begin
                falls++; lcol = s_col; lrow = s_row;
            end
            prev_vs = s_vs;
        end

        // Previous pixel's output; cursor_en is sampled live during its overlay cycle.
        if (s_rst || p_rst) begin
            e_rgb = '0; e_hs = 1; e_vs = 1; e_bn = 0;
        end else begin
            e_hs = p_hs; e_vs = p_vs; e_bn = p_bn;
            ox = p_x % 40;
            oy = p_y % 40;
            if (!p_bn)
                e_rgb = '0;
            else if (s_cen && p_blink && p_lrow < 12 && p_x / 40 == p_lcol && p_y / 40 == p_lrow &&
                     (ox < 2 || ox >= 38 || oy < 2 || oy >= 38))
                e_rgb = 24'hFFFF00;
            else if (p_hit && p_sc != 24'hFF00FF)
                e_rgb = p_sc;
            else
                e_rgb = ram_word(19'(model_addr(p_x, p_y)));
        end

        p_x = s_x; p_y = s_y; p_hit = s_hit; p_sc = s_sc; p_bn = s_bn;
        p_hs = s_hs; p_vs = s_vs; p_rst = s_rst;
        p_blink = ((falls / 16) % 2) == 0;
        p_lcol = lcol; p_lrow = lrow;
        started = 1;
    endtask

    task automatic vs_pulse();
        s_vs = 0; tick();
        s_vs = 1; tick();
    endtask

    task automatic pix(input int x, input int y);
        s_x = x; s_y = y; tick();
    endtask

    initial begin
        repeat (3) tick();
        s_rst = 0;

        pix(5, 3);
        pix(640, 0);
        s_hs = 0; pix(5, 3);
        s_hs = 1;
        s_hit = 1; s_sc = 24'hFF00FF; pix(5, 3);
        s_sc = 24'h00FF00; pix(5, 3);
        s_bn = 0; pix(5, 3);
        s_bn = 1; s_hit = 0;

        s_cen = 1; s_col = 2; s_row = 1;
        vs_pulse();
        pix(80, 40); pix(100, 60); pix(119, 59);
        repeat (15) vs_pulse();
        pix(80, 40); pix(119, 59);
        repeat (16) vs_pulse();
        pix(80, 40); pix(119, 59); pix(100, 60);

        s_col = 15; s_row = 11; vs_pulse();
        pix(600, 440); pix(639, 479);
        s_row = 12; vs_pulse();
        pix(600, 480); pix(639, 519); pix(600, 440);

        s_col = 3; s_row = 2; vs_pulse();
        for (int i = 0; i < 6; i++) pix(120 + i, 80);
        s_rst = 1;
        for (int i = 0; i < 3; i++) pix(126 + i, 80);
        s_rst = 0;
        for (int i = 0; i < 5; i++) pix(120 + i, 80);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                s_x = lcol * 40 + int'($urandom_range(0, 39));
                s_y = lrow * 40 + int'($urandom_range(0, 39));
            end else begin
                s_x = int'($urandom_range(0, 700));
                s_y = int'($urandom_range(0, 520));
            end
            s_hs = ($urandom_range(0, 7) != 0);
            s_vs = ($urandom_range(0, 4) != 0);
            s_bn = ($urandom_range(0, 7) != 0);
            s_hit = ($urandom_range(0, 2) == 0);
            s_sc = ($urandom_range(0, 3) == 0) ? 24'hFF00FF : 24'($urandom);
            s_cen = ($urandom_range(0, 3) != 0);
            s_col = int'($urandom_range(0, 15));
            s_row = int'($urandom_range(0, 13));
            s_rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        s_rst = 0;
        s_vs = 1;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_pixel_pipe.md
Name: vga_pixel_pipe

Overview:
- Pixel-stream stage around the map RAM: converts the VGA controller's DrawX/DrawY into the map RAM read address, then consumes the 24-bit map colour returned one clock later.
- Overlays the tower/enemy sprite colour (transparency-keyed) and a blinking tile cursor on that map colour.
- Delays HS/VS/BLANK to match the data path and drives the VGA DAC pins.
- Sits between the VGA controller/sprite logic and the top-level VGA outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
KEY_COLOR, 24'hFF00FF, sprite colour treated as transparent
TILE_PX, 40, cursor tile size in pixels (16x12 grid)
CURSOR_COLOR, 24'hFFFF00, cursor border colour
BORDER_PX, 2, cursor border thickness
BLINK_FRAMES, 16, frames per cursor blink half-period

Ports:
Clk  in  1  pixel clock; every stage advances every cycle
Reset  in  1  synchronous, active-high
DrawX  in  10  current pixel column from the VGA controller
DrawY  in  10  current pixel line
hs_in  in  1  horizontal sync, active-low, aligned with DrawX/DrawY
vs_in  in  1  vertical sync, active-low, aligned with DrawX/DrawY
blank_n_in  in  1  active-video flag, active-low blank, aligned with DrawX/DrawY
sprite_hit  in  1  a sprite covers (DrawX,DrawY), aligned with DrawX/DrawY
sprite_color  in  24  sprite RGB for that pixel
cursor_en  in  1  cursor display enable
cursor_col  in  4  cursor tile column
cursor_row  in  4  cursor tile row
map_read_address  out  19  to the map RAM read_address
map_data_in  in  24  from the map RAM data_Out_map1; 1-cycle read latency
VGA_R, VGA_G, VGA_B  out  8 each  output colour
VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  delayed syncs/blank

Behaviour:
- Stage 0, cycle t: map_read_address is combinational from DrawX/DrawY.
  - In the active area (DrawX<H_ACTIVE and DrawY<V_ACTIVE), it is DrawY*640+DrawX, computed as (DrawY<<9)+(DrawY<<7)+DrawX, zero-extended to 19 bits.
  - Otherwise it is 0.
- Stage 1, cycle t+1: map_data_in is valid. sprite_hit, sprite_color, DrawX, DrawY and blank_n_in are registered once, so they align with map_data_in.
- Stage 1 colour select, in priority order:
  1. blank_d1 low -> 24'h0.
  2. cursor_vis and the pixel lies in the BORDER_PX-wide border of tile (cur_col_l, cur_row_l) -> CURSOR_COLOR.
  3. sprite_hit_d1 and sprite_color_d1 != KEY_COLOR -> sprite_color_d1.
  4. Otherwise -> map_data_in.
- Stage 2, cycle t+2: the selected colour is registered onto VGA_R=[23:16], VGA_G=[15:8], VGA_B=[7:0].
  - hs_in, vs_in and blank_n_in pass through a 2-deep shift register to VGA_HS/VGA_VS/VGA_BLANK_N.
  - Total latency is exactly 2 clocks for every output.
- Tile test: tile x = DrawX_d1 / TILE_PX, tile y = DrawY_d1 / TILE_PX, offsets are the remainders.
  - Border when offset_x < BORDER_PX, offset_x >= TILE_PX-BORDER_PX, or the same conditions on offset_y.
  - Division by a constant may be implemented as a compare chain.
- Frame start is the falling edge of vs_in, detected against vs_in registered once. At frame start:
  - cur_col_l/cur_row_l latch cursor_col/cursor_row, so the cursor never tears mid-frame.
  - frame_cnt (4 bits) increments. When frame_cnt == BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
- cursor_vis = cursor_en & blink_on & (cur_col_l<16) & (cur_row_l<12). An out-of-range latched tile draws nothing.
- cursor_en is sampled live; it is not latched.
- Reset values:
  - VGA_R/G/B = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0.
  - All delay registers take the same values: syncs 1, blank 0, colour 0.
  - frame_cnt = 0, blink_on = 1, cur_col_l = cur_row_l = 0, vs edge register = 1.
- Reset mid-frame: outputs take reset values on the first edge with Reset high and hold them while Reset is high.
  - map_read_address remains combinational throughout.
  - The first post-reset pixel appears 2 clocks after Reset falls.
- A vs edge coinciding with Reset is ignored.
- Simultaneous frame start and blink wrap: the cursor latch and the toggle happen in the same cycle.

Decomposition:
- Package vga_pkg holds H_ACTIVE, V_ACTIVE, the rgb24_t typedef (24 bits), and the KEY_COLOR/CURSOR_COLOR constants.
- Sub-module cursor_blink holds the vs edge detect, frame_cnt, blink_on and the cursor latches. Its outputs are blink_on, cur_col_l and cur_row_l.
- The pipeline and mux stay in vga_pixel_pipe.

Test Plan:
- DrawX=5, DrawY=3 -> map_read_address=1925 in the same cycle. DrawX=640, DrawY=0 -> address 0.
- Model RAM returns 24'h123456 one clock after address 1925, no sprite, cursor off -> VGA_R/G/B=12/34/56 exactly 2 clocks after the DrawX/DrawY cycle, and VGA_HS matches hs_in delayed 2.
- sprite_hit=1 with sprite_color=24'hFF00FF -> map colour out. sprite_color=24'h00FF00 -> 00/FF/00. blank_n_in=0 -> 00/00/00 regardless.
- cursor_en=1, col=2, row=1, after one vs falling edge: pixel (80,40) -> CURSOR_COLOR; (100,60) -> map colour; (119,59) -> CURSOR_COLOR.
- 16 vs falling edges -> blink_on toggles to 0 and the cursor disappears. 16 more edges -> it reappears. cursor_col=15 then row=12 -> no cursor drawn.
- Reset asserted mid-line for 3 clocks -> the next edge gives RGB=0, HS=VS=1, BLANK_N=0, frame_cnt=0, blink_on=1. Valid pixels resume 2 clocks after release.
